uart_tx_ctrl: RTL



---
 rtl/uart_tx_pkg.sv | 21 ++
 rtl/uart_tx_ctrl_if.sv | 25 ++
 rtl/uart_tx_serializer.sv | 38 +++
 rtl/uart_tx_ctrl.sv | 96 +++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmit frame sequencer.
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Select codes for the downstream registered 4:1 TX mux
  localparam logic [1:0] SEL_START = 2'b00;
  localparam logic [1:0] SEL_STOP  = 2'b01;
  localparam logic [1:0] SEL_DATA  = 2'b10;
  localparam logic [1:0] SEL_PAR   = 2'b11;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_ctrl_if.sv
// Upstream byte handshake plus the signals feeding the TX output mux.
interface uart_tx_ctrl_if #(parameter int DATA_WIDTH = 8);
  import uart_tx_pkg::*;

  logic                  data_valid;
  logic [DATA_WIDTH-1:0] p_data;
  logic                  par_en;
  logic                  par_typ;
  logic                  ready;
  logic [1:0]            mux_sel;
  logic                  ser_data;
  logic                  par_bit;
  logic                  busy;

  modport master (
    output data_valid, p_data, par_en, par_typ,
    input  ready, mux_sel, ser_data, par_bit, busy
  );

  modport slave (
    input  data_valid, p_data, par_en, par_typ,
    output ready, mux_sel, ser_data, par_bit, busy
  );

endinterface

// File: rtl/uart_tx_serializer.sv
// Holds the accepted payload and a bit index; presents the payload LSB first.
module uart_tx_serializer
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  load,
  input  logic                  shift_en,
  input  logic [DATA_WIDTH-1:0] load_data,
  output logic                  ser_data,
  output logic                  ser_done
);

  localparam int CNT_W = $clog2(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] data_q;
  logic [CNT_W-1:0]      cnt_q;

  // Payload latch and bit index; the index parks on the last bit so it never
  // points outside the payload between frames.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      data_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      data_q <= load_data;
      cnt_q  <= '0;
    end else if (shift_en && !ser_done) begin
      cnt_q  <= cnt_q + CNT_W'(1);
    end
  end

  assign ser_done = (cnt_q == CNT_W'(DATA_WIDTH - 1));
  assign ser_data = data_q[cnt_q];

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART TX frame sequencer: START -> DATA (LSB first) -> [PARITY] -> STOP.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | line idle (mux in1 = 1), waiting for a byte
// ST_START  | start bit (mux in0 = 0), payload and config just latched
// ST_DATA   | payload bits from the serializer, one per clock
// ST_PARITY | parity bit (only when the latched par_en is set)
// ST_STOP   | stop bit; a byte accepted here starts the next frame at once
module uart_tx_ctrl
  import uart_tx_pkg::*;
#(
  parameter int DATA_WIDTH = 8
) (
  input logic           CLK,
  input logic           RST,
  uart_tx_ctrl_if.slave bus
);

  tx_state_t  state;
  logic [1:0] mux_sel_q;
  logic       busy_q;
  logic       par_bit_q;
  logic       par_en_q;
  logic       ser_done;
  logic       ser_data;
  logic       accept;
  logic       ready;

  assign ready  = (state == ST_IDLE) || (state == ST_STOP);
  assign accept = bus.data_valid && ready;

  uart_tx_serializer #(.DATA_WIDTH(DATA_WIDTH)) u_ser (
    .CLK       (CLK),
    .RST       (RST),
    .load      (accept),
    .shift_en  (state == ST_DATA),
    .load_data (bus.p_data),
    .ser_data  (ser_data),
    .ser_done  (ser_done)
  );

  // Frame FSM; mux select and busy are registered alongside the next state
  // so they track the state register exactly.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= ST_IDLE;
      mux_sel_q <= SEL_STOP;
      busy_q    <= 1'b0;
      par_bit_q <= 1'b0;
      par_en_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_STOP: begin
          if (accept) begin
            state     <= ST_START;
            mux_sel_q <= SEL_START;
            busy_q    <= 1'b1;
            par_en_q  <= bus.par_en;
            par_bit_q <= (bus.par_typ == PAR_ODD) ? ~^bus.p_data : ^bus.p_data;
          end else begin
            state     <= ST_IDLE;
            mux_sel_q <= SEL_STOP;
            busy_q    <= 1'b0;
          end
        end
        ST_START: begin
          state     <= ST_DATA;
          mux_sel_q <= SEL_DATA;
        end
        ST_DATA: begin
          if (ser_done) begin
            state     <= par_en_q ? ST_PARITY : ST_STOP;
            mux_sel_q <= par_en_q ? SEL_PAR : SEL_STOP;
          end
        end
        ST_PARITY: begin
          state     <= ST_STOP;
          mux_sel_q <= SEL_STOP;
        end
        default: begin
          state     <= ST_IDLE;
          mux_sel_q <= SEL_STOP;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready    = ready;
  assign bus.mux_sel  = mux_sel_q;
  assign bus.busy     = busy_q;
  assign bus.par_bit  = par_bit_q;
  assign bus.ser_data = ser_data;

endmodule
